split_eval_ctrl: RTL and testbench

SPLIT_EVAL_CTRL -- requirements
Module: split_eval_ctrl

---
 rtl/split_eval_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_split_eval_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_eval_ctrl.sv
// -----------------------------------------------------------------------------
// split_eval_ctrl
//   Sequences up to NUM_SPLITS split constraint checkers in ascending index
//   order. Each enabled split is requested once; the pass ends early on the
//   first violated split or on a checker that does not answer within TMO_CYC
//   cycles. Verdict, failing index and timeout flag hold until the next start.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   start        begin a pass (sampled in IDLE only)
//   split_mask   per-split enable, captured on accepted start
//   busy         high in every state but IDLE
//   eval_req     request to the checker selected by eval_idx
//   eval_idx     index of the split being evaluated
//   eval_ack     checker response strobe, eval_result valid with it
//   eval_result  checker verdict: 1 satisfied, 0 violated
//   done         one-cycle pulse at pass completion
//   pass         verdict of last pass: 1 all enabled splits satisfied
//   fail_idx     failing or timed-out split index, 0 on pass
//   timeout      last pass ended by response timeout
//   pass_cnt     saturating count of passing evaluations
//   fail_cnt     saturating count of failing / timed-out evaluations
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// SCAN  | inspect mask bit at idx; skip disabled splits one per cycle
// REQ   | eval_req held for split idx until ack or timer terminal count
// DONE  | one-cycle done pulse, counters updated on exit
// -----------------------------------------------------------------------------
module split_eval_ctrl #(
  parameter int NUM_SPLITS = 8,
  parameter int IDX_W      = 3,
  parameter int TMO_CYC    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_SPLITS-1:0] split_mask,
  output logic                  busy,
  output logic                  eval_req,
  output logic [IDX_W-1:0]      eval_idx,
  input  logic                  eval_ack,
  input  logic                  eval_result,
  output logic                  done,
  output logic                  pass,
  output logic [IDX_W-1:0]      fail_idx,
  output logic                  timeout,
  output logic [15:0]           pass_cnt,
  output logic [15:0]           fail_cnt
);

  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  // Down-counter loaded on REQ entry; reaching zero equals TMO_CYC-1 cycles elapsed.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SPLITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                  state_q;
  logic [NUM_SPLITS-1:0]   mask_q;
  logic [IDX_W-1:0]        idx_q;
  logic [TMO_W-1:0]        tmr_q;
  logic                    busy_q;
  logic                    eval_req_q;
  logic                    done_q;
  logic                    pass_q;
  logic [IDX_W-1:0]        fail_idx_q;
  logic                    timeout_q;
  logic [15:0]             pass_cnt_q;
  logic [15:0]             fail_cnt_q;

  logic                    idx_last;
  logic [15:0]             pass_cnt_d;
  logic [15:0]             fail_cnt_d;

  assign idx_last   = (idx_q == IDX_LAST);
  assign pass_cnt_d = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
  assign fail_cnt_d = (fail_cnt_q == 16'hFFFF) ? fail_cnt_q : fail_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      busy_q     <= 1'b0;
      eval_req_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      timeout_q  <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_q     <= split_mask;
            idx_q      <= '0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (mask_q[idx_q]) begin
            tmr_q      <= TMO_LOAD;
            eval_req_q <= 1'b1;
            state_q    <= S_REQ;
          end else if (idx_last) begin
            pass_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        S_REQ: begin
          // Ack wins over a coincident timer terminal count.
          if (eval_ack) begin
            eval_req_q <= 1'b0;
            if (!eval_result) begin
              fail_idx_q <= idx_q;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else if (idx_last) begin
              pass_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_SCAN;
            end
          end else if (tmr_q == '0) begin
            eval_req_q <= 1'b0;
            timeout_q  <= 1'b1;
            fail_idx_q <= idx_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            tmr_q <= tmr_q - TMO_W'(1);
          end
        end

        S_DONE: begin
          if (pass_q) begin
            pass_cnt_q <= pass_cnt_d;
          end else begin
            fail_cnt_q <= fail_cnt_d;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q     <= 1'b0;
          eval_req_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign eval_req = eval_req_q;
  assign eval_idx = idx_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;
  assign timeout  = timeout_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_split_eval_ctrl.sv
// -----------------------------------------------------------------------------
// tb_split_eval_ctrl
//   Drives passes through split_eval_ctrl with a per-split checker plan
//   (ack latency, result, or never answering) and compares what it observes
//   against an outcome computed by walking the plan in index order.
// -----------------------------------------------------------------------------
module tb_split_eval_ctrl;

  localparam int NS  = 8;
  localparam int IW  = 3;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NS-1:0] split_mask;
  logic          busy;
  logic          eval_req;
  logic [IW-1:0] eval_idx;
  logic          eval_ack;
  logic          eval_result;
  logic          done;
  logic          pass;
  logic [IW-1:0] fail_idx;
  logic          timeout;
  logic [15:0]   pass_cnt;
  logic [15:0]   fail_cnt;

  split_eval_ctrl #(.NUM_SPLITS(NS), .IDX_W(IW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .split_mask(split_mask),
    .busy(busy), .eval_req(eval_req), .eval_idx(eval_idx),
    .eval_ack(eval_ack), .eval_result(eval_result), .done(done),
    .pass(pass), .fail_idx(fail_idx), .timeout(timeout),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // checker plan
  int lat[NS];
  bit res[NS];
  bit never[NS];

  // observations of one pass
  int          o_cycles;
  logic        o_pass, o_timeout;
  logic [IW-1:0] o_fail_idx;
  logic [NS-1:0] o_req_mask;
  int          o_req_cycles;
  bit          o_busy_ok, o_hung, o_idx_stable, o_post_idle, o_cleared;

  // expected outcome
  int          e_cycles;
  bit          e_pass, e_timeout;
  int          e_fail_idx;
  logic [NS-1:0] e_req_mask;
  int          e_req_cycles;
  int          m_pass_cnt = 0;
  int          m_fail_cnt = 0;

  task automatic plan_clear();
    for (int i = 0; i < NS; i++) begin
      lat[i] = 0; res[i] = 1'b1; never[i] = 1'b0;
    end
  endtask

  // Walk the splits: one SCAN cycle each, plus latency+1 REQ cycles for enabled
  // ones (TMO on no answer); done lands on the cycle after the last of these.
  task automatic model(input logic [NS-1:0] m);
    e_cycles = 0; e_pass = 1'b1; e_timeout = 1'b0; e_fail_idx = 0;
    e_req_mask = '0; e_req_cycles = 0;
    for (int i = 0; i < NS; i++) begin
      e_cycles++;
      if (m[i]) begin
        e_req_mask[i] = 1'b1;
        if (never[i] || lat[i] >= TMO) begin
          e_cycles += TMO; e_req_cycles += TMO;
          e_pass = 1'b0; e_timeout = 1'b1; e_fail_idx = i;
          break;
        end
        e_cycles += lat[i] + 1; e_req_cycles += lat[i] + 1;
        if (!res[i]) begin
          e_pass = 1'b0; e_fail_idx = i;
          break;
        end
      end
    end
    e_cycles++;
    if (e_pass) m_pass_cnt++; else m_fail_cnt++;
  endtask

  // Start a pass and act as the checkers; cycle k is the k-th cycle after the start cycle.
  task automatic run_pass(input logic [NS-1:0] m, input bit noise);
    int rc;
    logic [IW-1:0] last_idx;
    bit in_req;
    rc = 0; last_idx = '0; in_req = 1'b0;
    o_req_mask = '0; o_req_cycles = 0; o_busy_ok = 1'b1; o_hung = 1'b1;
    o_idx_stable = 1'b1; o_cycles = 0; o_post_idle = 1'b0; o_cleared = 1'b0;
    o_pass = 1'b0; o_timeout = 1'b0; o_fail_idx = '0;
    @(negedge clk);
    start = 1'b1; split_mask = m; eval_ack = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      start = 1'b0;
      split_mask = noise ? NS'($urandom) : m;
      if (k == 1) o_cleared = (pass === 1'b0) && (timeout === 1'b0) && (fail_idx === '0);
      if (busy !== 1'b1) o_busy_ok = 1'b0;
      if (eval_req === 1'b1) begin
        if (in_req && eval_idx !== last_idx) o_idx_stable = 1'b0;
        if (!in_req) rc = 0;
        in_req = 1'b1; last_idx = eval_idx;
        o_req_mask[eval_idx] = 1'b1; o_req_cycles++;
        if (!never[eval_idx] && rc == lat[eval_idx]) begin
          eval_ack = 1'b1; eval_result = res[eval_idx];
        end else begin
          eval_ack = 1'b0; eval_result = 1'($urandom);
        end
        rc++;
      end else begin
        in_req = 1'b0;
        eval_ack = noise ? 1'($urandom) : 1'b0;
        eval_result = 1'($urandom);
      end
      if (noise) start = 1'($urandom);
      if (done === 1'b1) begin
        o_cycles = k; o_pass = pass; o_timeout = timeout; o_fail_idx = fail_idx;
        o_hung = 1'b0; start = 1'b0; eval_ack = 1'b0;
        break;
      end
    end
    @(negedge clk);
    o_post_idle = (busy === 1'b0) && (done === 1'b0) && (eval_req === 1'b0);
    start = 1'b0; eval_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; split_mask = '0; eval_ack = 1'b0; eval_result = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, eval_req, eval_idx, done, pass, fail_idx, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b req=%b idx=%0d done=%b pass=%b fidx=%0d tmo=%b, required all 0",
               busy, eval_req, eval_idx, done, pass, fail_idx, timeout);
    end
    n_checks++;
    if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d required 0/0", pass_cnt, fail_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_pass();
    plan_clear();
    model(8'hFF);
    run_pass(8'hFF, 1'b0);
    n_checks++;
    if (o_hung || o_cycles !== 17) begin
      n_fail++; $display("FAIL all_pass_latency: got %0d (hung=%0b) required 17", o_cycles, o_hung);
    end
    n_checks++;
    if (o_pass !== 1'b1 || o_timeout !== 1'b0 || o_fail_idx !== '0) begin
      n_fail++; $display("FAIL all_pass_verdict: got pass=%b tmo=%b fidx=%0d required 1/0/0", o_pass, o_timeout, o_fail_idx);
    end
    n_checks++;
    if (pass_cnt !== 16'(m_pass_cnt) || pass_cnt !== 16'd1) begin
      n_fail++; $display("FAIL all_pass_cnt: got %0d required 1", pass_cnt);
    end
    n_checks++;
    if (!o_busy_ok || !o_post_idle || !o_idx_stable) begin
      n_fail++; $display("FAIL all_pass_busy: got busy_ok=%0b post_idle=%0b stable=%0b required 1/1/1", o_busy_ok, o_post_idle, o_idx_stable);
    end
  endtask

  task automatic test_fail5();
    plan_clear();
    res[5] = 1'b0;
    model(8'hFF);
    run_pass(8'hFF, 1'b0);
    n_checks++;
    if (o_hung || o_pass !== 1'b0 || o_fail_idx !== 3'd5 || o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL fail5_verdict: got pass=%b fidx=%0d tmo=%b required 0/5/0", o_pass, o_fail_idx, o_timeout);
    end
    n_checks++;
    if (o_req_mask !== 8'h3F) begin
      n_fail++; $display("FAIL fail5_req_set: got %0h required 3f", o_req_mask);
    end
    n_checks++;
    if (o_cycles !== e_cycles) begin
      n_fail++; $display("FAIL fail5_latency: got %0d required %0d", o_cycles, e_cycles);
    end
    n_checks++;
    if (fail_cnt !== 16'(m_fail_cnt) || fail_cnt !== 16'd1) begin
      n_fail++; $display("FAIL fail5_cnt: got %0d required 1", fail_cnt);
    end
  endtask

  task automatic test_timeout();
    plan_clear();
    never[2] = 1'b1;
    model(8'h04);
    run_pass(8'h04, 1'b0);
    n_checks++;
    if (o_hung || o_req_cycles !== TMO || o_cycles !== e_cycles) begin
      n_fail++; $display("FAIL timeout_hold: got req_cycles=%0d done_at=%0d required %0d/%0d", o_req_cycles, o_cycles, TMO, e_cycles);
    end
    n_checks++;
    if (o_timeout !== 1'b1 || o_fail_idx !== 3'd2 || o_pass !== 1'b0) begin
      n_fail++; $display("FAIL timeout_verdict: got tmo=%b fidx=%0d pass=%b required 1/2/0", o_timeout, o_fail_idx, o_pass);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (timeout !== 1'b1 || fail_idx !== 3'd2 || fail_cnt !== 16'(m_fail_cnt)) begin
      n_fail++; $display("FAIL timeout_sticky: got tmo=%b fidx=%0d fcnt=%0d required 1/2/%0d", timeout, fail_idx, fail_cnt, m_fail_cnt);
    end
  endtask

  task automatic test_zero_mask();
    plan_clear();
    model(8'h00);
    run_pass(8'h00, 1'b1);
    n_checks++;
    if (o_hung || o_cycles !== 9 || o_pass !== 1'b1) begin
      n_fail++; $display("FAIL zero_mask: got done_at=%0d pass=%b required 9/1", o_cycles, o_pass);
    end
    n_checks++;
    if (o_req_mask !== 8'h00 || !o_post_idle || pass_cnt !== 16'(m_pass_cnt)) begin
      n_fail++; $display("FAIL zero_mask_req: got reqs=%0h post_idle=%0b pcnt=%0d required 0/1/%0d", o_req_mask, o_post_idle, pass_cnt, m_pass_cnt);
    end
  endtask

  task automatic test_ack_at_expiry();
    plan_clear();
    lat[2] = TMO - 1;
    model(8'h04);
    run_pass(8'h04, 1'b0);
    n_checks++;
    if (o_hung || o_pass !== 1'b1 || o_timeout !== 1'b0 || o_cycles !== e_cycles) begin
      n_fail++; $display("FAIL ack_at_expiry: got pass=%b tmo=%b done_at=%0d required 1/0/%0d", o_pass, o_timeout, o_cycles, e_cycles);
    end
    n_checks++;
    if (!o_cleared) begin
      n_fail++; $display("FAIL start_clears_verdict: got 0 required 1");
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    plan_clear();
    never[2] = 1'b1;
    seen = 1'b0;
    @(negedge clk); start = 1'b1; split_mask = 8'h04;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (eval_req === 1'b1);
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL reset_mid_reach_req: got 0 required 1");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pass_cnt = 0; m_fail_cnt = 0;
    n_checks++;
    if (eval_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid: got req=%b busy=%b done=%b cnt=%0d/%0d required 0/0/0/0/0", eval_req, busy, done, pass_cnt, fail_cnt);
    end
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL reset_mid_no_done: got activity after reset required none");
    end
  endtask

  task automatic test_random();
    logic [NS-1:0] m;
    for (int p = 0; p < 30; p++) begin
      m = NS'($urandom);
      for (int i = 0; i < NS; i++) begin
        lat[i]   = ($urandom % 4 == 0) ? int'($urandom_range(0, TMO - 1)) : int'($urandom_range(0, 3));
        never[i] = ($urandom % 10 == 0);
        res[i]   = ($urandom % 8 != 0);
      end
      model(m);
      run_pass(m, 1'($urandom));
      n_checks++;
      if (o_hung || o_cycles !== e_cycles) begin
        n_fail++; $display("FAIL rand_latency[%0d] mask=%0h: got %0d (hung=%0b) required %0d", p, m, o_cycles, o_hung, e_cycles);
      end
      n_checks++;
      if (o_pass !== e_pass || o_timeout !== e_timeout || o_fail_idx !== IW'(e_fail_idx)) begin
        n_fail++; $display("FAIL rand_verdict[%0d] mask=%0h: got %b/%b/%0d required %b/%b/%0d",
                           p, m, o_pass, o_timeout, o_fail_idx, e_pass, e_timeout, e_fail_idx);
      end
      n_checks++;
      if (o_req_mask !== e_req_mask || o_req_cycles !== e_req_cycles) begin
        n_fail++; $display("FAIL rand_requests[%0d]: got %0h/%0d required %0h/%0d", p, o_req_mask, o_req_cycles, e_req_mask, e_req_cycles);
      end
      n_checks++;
      if (!o_busy_ok || !o_post_idle || !o_idx_stable || !o_cleared) begin
        n_fail++; $display("FAIL rand_handshake[%0d]: got busy=%0b idle=%0b stable=%0b cleared=%0b required all 1",
                           p, o_busy_ok, o_post_idle, o_idx_stable, o_cleared);
      end
      n_checks++;
      if (pass_cnt !== 16'(m_pass_cnt) || fail_cnt !== 16'(m_fail_cnt)) begin
        n_fail++; $display("FAIL rand_counters[%0d]: got %0d/%0d required %0d/%0d", p, pass_cnt, fail_cnt, m_pass_cnt, m_fail_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_fail5();
    test_timeout();
    test_zero_mask();
    test_ack_at_expiry();
    test_reset_mid();
    test_all_pass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
